// File: rtl/axis_pkt_gen.sv
// AXI-Stream packet generator: byte-incrementing pattern packets with
// programmable length, count and inter-frame gap.
module axis_pkt_gen #(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = (DATA_WIDTH + 7) / 8,
  parameter int LEN_WIDTH  = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  m_axis_aclk,
  input  logic                  m_axis_aresetn,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  pkt_len,
  input  logic [CNT_WIDTH-1:0]  pkt_count,
  input  logic [CNT_WIDTH-1:0]  ifg,
  input  logic [7:0]            seed,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           tx_pkts,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tlast
);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } state_t;

  localparam logic [LEN_WIDTH-1:0] KW_L = LEN_WIDTH'(KEEP_WIDTH);

  // Assert asynchronously, release on a clock edge.
  logic [1:0] rst_sr;
  logic       rst_n;

  always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) rst_sr <= 2'b00;
    else                 rst_sr <= {rst_sr[0], 1'b1};
  end

  assign rst_n = rst_sr[1];

  state_t                state_q, state_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]  ifg_q, ifg_d;
  logic [CNT_WIDTH-1:0]  p_q, p_d;
  logic [CNT_WIDTH-1:0]  gap_q, gap_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic [7:0]            pkt_byte_q, pkt_byte_d;
  logic [7:0]            beat_byte_q, beat_byte_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [31:0]           tx_q, tx_d;
  logic                  tvalid_q, tvalid_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic [KEEP_WIDTH-1:0] tkeep_q, tkeep_d;
  logic                  tlast_q, tlast_d;

  logic                  load;
  logic                  clr;
  logic [LEN_WIDTH-1:0]  ld_rem;
  logic [7:0]            ld_byte;

  always_ff @(posedge m_axis_aclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      ifg_q       <= '0;
      p_q         <= '0;
      gap_q       <= '0;
      rem_q       <= '0;
      pkt_byte_q  <= '0;
      beat_byte_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      tx_q        <= '0;
      tvalid_q    <= 1'b0;
      tdata_q     <= '0;
      tkeep_q     <= '0;
      tlast_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      ifg_q       <= ifg_d;
      p_q         <= p_d;
      gap_q       <= gap_d;
      rem_q       <= rem_d;
      pkt_byte_q  <= pkt_byte_d;
      beat_byte_q <= beat_byte_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      tx_q        <= tx_d;
      tvalid_q    <= tvalid_d;
      tdata_q     <= tdata_d;
      tkeep_q     <= tkeep_d;
      tlast_q     <= tlast_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    ifg_d       = ifg_q;
    p_d         = p_q;
    gap_d       = gap_q;
    rem_d       = rem_q;
    pkt_byte_d  = pkt_byte_q;
    beat_byte_d = beat_byte_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    tx_d        = tx_q;
    tvalid_d    = tvalid_q;
    tdata_d     = tdata_q;
    tkeep_d     = tkeep_q;
    tlast_d     = tlast_q;
    load        = 1'b0;
    clr         = 1'b0;
    ld_rem      = rem_q;
    ld_byte     = beat_byte_q;

    unique case (state_q)
      IDLE: begin
        if (start && pkt_len != '0 && pkt_count != '0) begin
          len_d      = pkt_len;
          cnt_d      = pkt_count;
          ifg_d      = ifg;
          p_d        = '0;
          pkt_byte_d = seed;
          busy_d     = 1'b1;
          state_d    = SEND;
          load       = 1'b1;
          ld_rem     = pkt_len;
          ld_byte    = seed;
        end
      end
      SEND: begin
        if (tvalid_q && m_axis_tready) begin
          if (!tlast_q) begin
            load    = 1'b1;
            ld_rem  = rem_q - KW_L;
            ld_byte = beat_byte_q + 8'(KEEP_WIDTH);
          end else begin
            tx_d       = tx_q + 32'd1;
            p_d        = p_q + 1'b1;
            pkt_byte_d = pkt_byte_q + 8'd1;
            if (p_d == cnt_q) begin
              state_d = IDLE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              clr     = 1'b1;
            end else if (ifg_q != '0) begin
              state_d = GAP;
              gap_d   = ifg_q;
              clr     = 1'b1;
            end else begin
              load    = 1'b1;
              ld_rem  = len_q;
              ld_byte = pkt_byte_q + 8'd1;
            end
          end
        end
      end
      GAP: begin
        // Counter holds the remaining idle cycles including this one.
        if (gap_q == CNT_WIDTH'(1)) begin
          state_d = SEND;
          load    = 1'b1;
          ld_rem  = len_q;
          ld_byte = pkt_byte_q;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      tvalid_d    = 1'b1;
      rem_d       = ld_rem;
      beat_byte_d = ld_byte;
      tdata_d     = '0;
      tkeep_d     = '0;
      for (int i = 0; i < KEEP_WIDTH; i++) begin
        if (LEN_WIDTH'(i) < ld_rem) begin
          tdata_d[8*i +: 8] = ld_byte + 8'(i);
          tkeep_d[i]        = 1'b1;
        end
      end
      tlast_d = (ld_rem <= KW_L);
    end else if (clr) begin
      tvalid_d = 1'b0;
      tdata_d  = '0;
      tkeep_d  = '0;
      tlast_d  = 1'b0;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign tx_pkts       = tx_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tkeep  = tkeep_q;
  assign m_axis_tlast  = tlast_q;

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Bench for axis_pkt_gen: table + random runs scored against a
// per-byte packet model, plus reset and ignored-start sequences.
module tb_axis_pkt_gen;

  localparam int DW = 64;
  localparam int KW = 8;
  localparam int LW = 16;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic [LW-1:0] len = '0;
  logic [CW-1:0] cnt = '0;
  logic [CW-1:0] ifg = '0;
  logic [7:0]    seed = '0;
  logic          busy, done, tvalid, tlast;
  logic          tready = 1'b0;
  logic [31:0]   tx_pkts;
  logic [DW-1:0] tdata;
  logic [KW-1:0] tkeep;

  axis_pkt_gen #(
    .DATA_WIDTH(DW),
    .KEEP_WIDTH(KW),
    .LEN_WIDTH (LW),
    .CNT_WIDTH (CW)
  ) dut (
    .m_axis_aclk   (clk),
    .m_axis_aresetn(rstn),
    .start         (start),
    .pkt_len       (len),
    .pkt_count     (cnt),
    .ifg           (ifg),
    .seed          (seed),
    .busy          (busy),
    .done          (done),
    .tx_pkts       (tx_pkts),
    .m_axis_tvalid (tvalid),
    .m_axis_tready (tready),
    .m_axis_tdata  (tdata),
    .m_axis_tkeep  (tkeep),
    .m_axis_tlast  (tlast)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
  } beat_t;

  typedef struct {
    int len;
    int cnt;
    int ifg;
    int seed;
    int pct;
    int beats;
  } vec_t;

  int    errors = 0;
  int    checks = 0;
  beat_t exp_q[$];
  int    pct = 100;
  bit    mon_en = 1'b0;
  int    beats_seen = 0;
  int    gap_cnt = 0;
  int    run_ifg = 0;
  int    done_cnt = 0;
  bit    gap_arm = 1'b0;
  bit    prev_stall = 1'b0;
  beat_t held;
  beat_t first_b;

  task automatic chk(input string nm, input logic [79:0] act,
                     input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: every byte offset k of packet p carries seed+p+k.
  function automatic void build(input vec_t v);
    int nb;
    beat_t e;
    nb = (v.len + KW - 1) / KW;
    for (int p = 0; p < v.cnt; p++) begin
      for (int b = 0; b < nb; b++) begin
        e = '0;
        for (int i = 0; i < KW; i++) begin
          int k;
          k = b * KW + i;
          if (k < v.len) begin
            e.d[8*i +: 8] = 8'((v.seed + p + k) % 256);
            e.k[i] = 1'b1;
          end
        end
        e.l = (b == nb - 1);
        exp_q.push_back(e);
      end
    end
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #1;
      tready = (int'($urandom_range(99)) < pct);
    end
  end

  always @(negedge clk) begin
    beat_t cur;
    beat_t e;
    cur = {tdata, tkeep, tlast};
    if (done) done_cnt++;
    if (mon_en) begin
      if (prev_stall) begin
        chk("hold_valid", 80'(tvalid), 80'(1));
        chk("hold_beat", 80'(cur), 80'(held));
      end
      if (tvalid && tready) begin
        chk("beat_expected", 80'(exp_q.size() != 0), 80'(1));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("beat", 80'(cur), 80'(e));
        end
        if (beats_seen == 0) first_b = cur;
        beats_seen++;
        if (gap_arm) begin
          chk("ifg", 80'(gap_cnt), 80'(run_ifg));
          gap_arm = 1'b0;
        end
        if (tlast) begin
          gap_arm = 1'b1;
          gap_cnt = 0;
        end
      end else if (!tvalid && gap_arm && busy) begin
        gap_cnt++;
      end
      prev_stall = tvalid && !tready;
      held = cur;
    end
  end

  task automatic run(input vec_t v, input string nm, input bit poke);
    int t;
    logic [31:0] tx0;
    int d0;
    exp_q.delete();
    build(v);
    tx0 = tx_pkts;
    d0 = done_cnt;
    beats_seen = 0;
    gap_arm = 1'b0;
    run_ifg = v.ifg;
    pct = v.pct;
    @(posedge clk);
    #2;
    start = 1'b1;
    len = LW'(v.len);
    cnt = CW'(v.cnt);
    ifg = CW'(v.ifg);
    seed = 8'(v.seed);
    @(posedge clk);
    #2;
    start = 1'b0;
    len = LW'($urandom);
    cnt = CW'($urandom);
    ifg = CW'($urandom);
    seed = 8'($urandom);
    chk({nm, "_busy_hi"}, 80'(busy), 80'(1));
    chk({nm, "_latency"}, 80'(tvalid), 80'(1));
    if (poke) begin
      @(posedge clk);
      #2;
      start = 1'b1;
      len = LW'(5);
      cnt = CW'(1);
      @(posedge clk);
      #2;
      start = 1'b0;
    end
    t = 0;
    while (!done && t < 20000) begin
      @(negedge clk);
      t++;
    end
    chk({nm, "_done"}, 80'(done), 80'(1));
    chk({nm, "_busy_lo"}, 80'(busy), 80'(0));
    chk({nm, "_valid_lo"}, 80'(tvalid), 80'(0));
    chk({nm, "_tx_pkts"}, 80'(tx_pkts), 80'(tx0 + 32'(v.cnt)));
    @(negedge clk);
    chk({nm, "_done_pulse"}, 80'(done), 80'(0));
    chk({nm, "_beats"}, 80'(beats_seen), 80'(v.beats));
    chk({nm, "_leftover"}, 80'(exp_q.size()), 80'(0));
    chk({nm, "_done_cnt"}, 80'(done_cnt - d0), 80'(1));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    vec_t tbl[6];
    vec_t v;
    int d0;
    tbl[0] = '{13, 1, 0, 0, 100, 2};
    tbl[1] = '{16, 3, 2, 'hFE, 100, 6};
    tbl[2] = '{100, 4, 1, 'h11, 50, 52};
    tbl[3] = '{8, 2, 0, 'h80, 100, 2};
    tbl[4] = '{1, 3, 0, 'hFF, 70, 3};
    tbl[5] = '{9, 2, 5, 3, 100, 4};

    repeat (3) @(negedge clk);
    chk("reset_outputs", 80'({busy, done, tvalid, tlast, tkeep, tdata}), 80'(0));
    chk("reset_tx_pkts", 80'(tx_pkts), 80'(0));
    rstn = 1'b1;
    repeat (4) @(posedge clk);
    mon_en = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run(tbl[i], $sformatf("tbl%0d", i), 1'b0);
      if (i == 0) begin
        chk("t1_beat0_data", 80'(first_b.d), 80'(64'h0706050403020100));
        chk("t1_beat0_keep", 80'(first_b.k), 80'(8'hFF));
      end
    end

    for (int i = 0; i < 6; i++) begin
      v.len = int'($urandom_range(1, 70));
      v.cnt = int'($urandom_range(1, 4));
      v.ifg = int'($urandom_range(0, 3));
      v.seed = int'($urandom_range(0, 255));
      v.pct = int'($urandom_range(30, 100));
      v.beats = v.cnt * ((v.len + KW - 1) / KW);
      run(v, $sformatf("rnd%0d", i), 1'b0);
    end

    pct = 100;
    d0 = done_cnt;
    @(posedge clk);
    #2;
    start = 1'b1;
    len = '0;
    cnt = CW'(3);
    @(posedge clk);
    #2;
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("zero_len_busy", 80'(busy), 80'(0));
    chk("zero_len_valid", 80'(tvalid), 80'(0));
    @(posedge clk);
    #2;
    start = 1'b1;
    len = LW'(5);
    cnt = '0;
    @(posedge clk);
    #2;
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("zero_cnt_busy", 80'(busy), 80'(0));
    chk("zero_cnt_valid", 80'(tvalid), 80'(0));
    chk("zero_no_done", 80'(done_cnt - d0), 80'(0));

    v = '{64, 3, 2, 5, 60, 24};
    run(v, "busy_start", 1'b1);

    pct = 0;
    exp_q.delete();
    @(posedge clk);
    #2;
    start = 1'b1;
    len = LW'(100);
    cnt = CW'(2);
    seed = 8'd9;
    @(posedge clk);
    #2;
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pre_valid", 80'(tvalid), 80'(1));
    mon_en = 1'b0;
    prev_stall = 1'b0;
    rstn = 1'b0;
    #1;
    chk("rst_valid", 80'(tvalid), 80'(0));
    chk("rst_busy", 80'(busy), 80'(0));
    chk("rst_tlast", 80'(tlast), 80'(0));
    chk("rst_tx", 80'(tx_pkts), 80'(0));
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (4) @(posedge clk);
    mon_en = 1'b1;
    v = '{20, 2, 1, 0, 100, 6};
    run(v, "after_rst", 1'b0);
    chk("after_rst_tx", 80'(tx_pkts), 80'(2));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
